leb128_encoder: RTL and testbench
=================================

Name: leb128_encoder

Overview:
- Converts a 64-bit integer into its LEB128 byte stream, unsigned (ULEB128) or signed (SLEB128).
- It is the write-side counterpart of the CPU's immediate decoder. Tooling and self-checking benches use it to build ROM images and stream operands into the core.
- Accepts one value per input handshake and emits 1-10 bytes on a byte-wide valid/ready output, with a last-byte flag.

Parameters:
- MAX_BYTES, 10, maximum bytes per encoding; must be ≥10 so that any 64-bit value fits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_data  input  64  value to encode
- in_signed  input  1  1 = SLEB128, 0 = ULEB128
- in_is32  input  1  1 = treat in_data[31:0] as an i32/u32 (sign-extend if in_signed, else zero-extend)
- in_valid  input  1  input value present
- in_ready  output  1  encoder can accept a value
- out_data  output  8  encoded byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts byte
- out_last  output  1  current byte is the final byte of the encoding
- out_count  output  4  index of the current byte within the encoding (0-based)

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - Ports are named clk and reset.
- Reset values: in_ready=1, out_valid=0, out_last=0, out_data=0, out_count=0, state=IDLE.
- State machine: two states, IDLE and EMIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch the extended value into the 64-bit shift register `rem`. With in_is32, take bits [31:0], sign-extended if in_signed, zero-extended otherwise.
  - Latch in_signed, clear the byte counter, go to EMIT.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_data = {~done, rem[6:0]}, where done is:
    - unsigned: (rem>>7)==0
    - signed: ((rem>>>7)==0 && rem[6]==0) || ((rem>>>7)==all-ones && rem[6]==1)
  - out_last = done. out_count = byte index.
- Byte advance:
  - On out_valid&out_ready with !done: rem <= rem>>7 (logical if unsigned, arithmetic if signed); counter++.
  - On out_valid&out_ready with done: return to IDLE.
- Latency:
  - First byte is valid the cycle after input acceptance.
  - Each subsequent byte follows one cycle after its predecessor's handshake.
  - Throughput is 1 byte/cycle when out_ready is held high.
  - in_ready rises the cycle after the last-byte handshake, so there is 1 bubble cycle between values.
- Backpressure:
  - While out_valid=1 and out_ready=0, out_data, out_last and out_count hold stable.
  - in_valid is ignored while in_ready=0.
- Computation: out_data, out_last and out_count are driven from registered state (rem, counter, state), never from in_* ports.
- Bounds:
  - Unsigned 64-bit encodings need ≤10 bytes; the all-ones value encodes as FF×9, 01.
  - Signed 64-bit encodings need ≤10 bytes.
  - Counter never exceeds 9. If it reaches MAX_BYTES-1, out_last is forced to 1 as a safety stop; this is unreachable for legal widths.
- Boundaries:
  - Value 0 encodes to a single byte 00 in both modes.
  - Signed -1 encodes to a single byte 7F.
  - Signed 64 encodes to C0 00, because bit 6 set would otherwise read as negative.
- Reset in EMIT: next cycle is IDLE, out_valid=0; the partial encoding is dropped.
- Simultaneous in_valid during the final byte handshake: not accepted that cycle, because in_ready=0.

Test Plan:
- Unsigned 624485, out_ready=1 → E5, 8E, 26; out_last only on 26; out_count 0,1,2; in_ready high 1 cycle after 26.
- Signed -123456 → C0, BB, 78; signed 127 → FF, 00; signed -1 → 7F; signed 64 → C0, 00.
- Unsigned 0xFFFFFFFFFFFFFFFF → FF×9 then 01, out_count=9 on last; with in_is32=1 and in_signed=0 → FF, FF, FF, FF, 0F.
- Backpressure: unsigned 300 (→AC, 02) with out_ready toggled 0/1 each cycle → AC held across stall cycles, same byte sequence, no duplication or loss.
- in_is32=1, in_signed=1, in_data=0x00000000_80000000 → 80, 80, 80, 80, 78 (encodes -2^31).
- Reset asserted mid-EMIT after first byte of 624485 → next cycle out_valid=0, in_ready=1; a following input of 5 yields single byte 05 with out_count=0.

Source files
------------

// File: rtl/leb128_encoder.sv
// LEB128 encoder: converts one 64-bit value per input handshake into its
// ULEB128 or SLEB128 byte stream on a byte-wide valid/ready output.
module leb128_encoder #(
    parameter int MAX_BYTES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] in_data,
    input  logic        in_signed,
    input  logic        in_is32,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic [3:0]  out_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    // Safety stop: the byte at this index always terminates the encoding.
    localparam logic [3:0] LAST_IDX = 4'(MAX_BYTES - 1);

    state_t      state_reg;
    logic [63:0] rem_reg;
    logic        sgn_reg;
    logic [3:0]  cnt_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;

    logic [63:0] ext_value;
    logic [63:0] rem_next;
    logic        done_u;
    logic        done_s;
    logic        done;

    // Input widening: 32-bit operands are sign- or zero-extended to 64 bits.
    always_comb begin
        ext_value = in_data;
        if (in_is32) begin
            ext_value = in_signed ? {{32{in_data[31]}}, in_data[31:0]}
                                  : {32'h0, in_data[31:0]};
        end
    end

    // Termination test on the remaining value, plus the next 7-bit shift.
    // For signed values the byte is final only when the rest is pure sign
    // extension AND bit 6 already carries that sign.
    always_comb begin
        done_u   = (rem_reg[63:7] == 57'h0);
        done_s   = ((rem_reg[63:7] == 57'h0) && !rem_reg[6]) ||
                   ((&rem_reg[63:7]) && rem_reg[6]);
        done     = (sgn_reg ? done_s : done_u) || (cnt_reg == LAST_IDX);
        rem_next = sgn_reg ? {{7{rem_reg[63]}}, rem_reg[63:7]}
                           : {7'h0, rem_reg[63:7]};
    end

    // Two-state FSM: accept a value in IDLE, stream its bytes in EMIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rem_reg       <= 64'h0;
            sgn_reg       <= 1'b0;
            cnt_reg       <= 4'h0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        rem_reg       <= ext_value;
                        sgn_reg       <= in_signed;
                        cnt_reg       <= 4'h0;
                        state_reg     <= EMIT;
                        in_ready_reg  <= 1'b0;
                        out_valid_reg <= 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (done) begin
                            state_reg     <= IDLE;
                            in_ready_reg  <= 1'b1;
                            out_valid_reg <= 1'b0;
                        end else begin
                            rem_reg <= rem_next;
                            cnt_reg <= cnt_reg + 4'h1;
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Output byte and flags come only from registered state, so they hold
    // steady under backpressure; idle outputs read as zero.
    always_comb begin
        in_ready  = in_ready_reg;
        out_valid = out_valid_reg;
        out_data  = out_valid_reg ? {~done, rem_reg[6:0]} : 8'h00;
        out_last  = out_valid_reg & done;
        out_count = cnt_reg;
    end

endmodule

// File: tb/tb_leb128_encoder.sv
// Directed bench for leb128_encoder with an expected-byte scoreboard.
module tb_leb128_encoder;

    logic        clk;
    logic        reset;
    logic [63:0] in_data;
    logic        in_signed;
    logic        in_is32;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic [3:0]  out_count;

    int checks = 0;
    int errors = 0;

    // Expected entry: {last, count[3:0], data[7:0]}
    logic [12:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [12:0] prev_out   = 13'h0;

    leb128_encoder #(.MAX_BYTES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_signed (in_signed),
        .in_is32   (in_is32),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Bytes are listed in emission order, first byte in the most significant slot.
    task automatic exp_push(input logic [79:0] bytes, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = bytes[8*(n-1-i) +: 8];
            exp_q.push_back({(i == n - 1), 4'(i), b});
        end
    endtask

    // Scoreboard: every output handshake is compared against the next expected byte;
    // a stalled byte must stay identical on the following cycle.
    always @(negedge clk) begin
        if (out_valid && prev_stall)
            check("stall_hold", {51'h0, out_last, out_count, out_data}, {51'h0, prev_out});
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {56'h0, out_data}, 64'hDEAD);
            end else begin
                logic [12:0] e;
                e = exp_q.pop_front();
                check("out_data", {56'h0, out_data}, {56'h0, e[7:0]});
                check("out_count", {60'h0, out_count}, {60'h0, e[11:8]});
                check("out_last", {63'h0, out_last}, {63'h0, e[12]});
                $display("byte %02h count=%0d last=%0b", out_data, out_count, out_last);
            end
        end
        prev_stall = out_valid && !out_ready && !reset;
        prev_out   = {out_last, out_count, out_data};
    end

    // Send one value and drain its encoding; optionally toggle out_ready each cycle.
    task automatic run(input string name, input logic [63:0] v, input logic s,
                       input logic i32, input logic toggle);
        logic finished;
        finished = 1'b0;
        @(posedge clk); #1;
        in_data   = v;
        in_signed = s;
        in_is32   = i32;
        in_valid  = 1'b1;
        out_ready = toggle ? 1'b0 : 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({name, "_first_valid"}, {63'h0, out_valid}, 64'h1);
        for (int c = 0; c < 60; c++) begin
            if (out_valid && out_ready && out_last) begin
                finished = 1'b1;
                break;
            end
            @(posedge clk); #1;
            if (toggle) out_ready = ~out_ready;
            @(negedge clk);
        end
        check({name, "_completed"}, {63'h0, finished}, 64'h1);
        check({name, "_in_ready_busy"}, {63'h0, in_ready}, 64'h0);
        @(negedge clk);
        check({name, "_in_ready_after"}, {63'h0, in_ready}, 64'h1);
        check({name, "_idle_valid"}, {63'h0, out_valid}, 64'h0);
        check({name, "_queue_empty"}, 64'(exp_q.size()), 64'h0);
        $display("value %s done", name);
        out_ready = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        in_data   = 64'h0;
        in_signed = 1'b0;
        in_is32   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_out_last", {63'h0, out_last}, 64'h0);
        check("rst_out_data", {56'h0, out_data}, 64'h0);
        check("rst_out_count", {60'h0, out_count}, 64'h0);

        exp_push(80'hE58E26, 3);
        run("u624485", 64'd624485, 1'b0, 1'b0, 1'b0);

        exp_push(80'hC0BB78, 3);
        run("s_m123456", 64'hFFFF_FFFF_FFFE_1DC0, 1'b1, 1'b0, 1'b0);

        exp_push(80'hFF00, 2);
        run("s127", 64'd127, 1'b1, 1'b0, 1'b0);

        exp_push(80'h7F, 1);
        run("s_m1", 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0);

        exp_push(80'hC000, 2);
        run("s64", 64'd64, 1'b1, 1'b0, 1'b0);

        exp_push(80'h00, 1);
        run("u0", 64'd0, 1'b0, 1'b0, 1'b0);

        exp_push(80'h00, 1);
        run("s0", 64'd0, 1'b1, 1'b0, 1'b0);

        exp_push(80'hFFFF_FFFF_FFFF_FFFF_FF01, 10);
        run("u_max64", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0);

        exp_push(80'hFFFF_FFFF_0F, 5);
        run("u_max32", 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0);

        exp_push(80'h8080_8080_78, 5);
        run("s_min32", 64'h0000_0000_8000_0000, 1'b1, 1'b1, 1'b0);

        exp_push(80'hAC02, 2);
        run("u300_stall", 64'd300, 1'b0, 1'b0, 1'b1);

        // Reset during EMIT: only the first byte of 624485 is consumed.
        exp_q.push_back({1'b0, 4'h0, 8'hE5});
        @(posedge clk); #1;
        in_data   = 64'd624485;
        in_signed = 1'b0;
        in_is32   = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_first", {63'h0, out_valid}, 64'h1);
        @(posedge clk); #1;
        reset     = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_mid_in_ready", {63'h0, in_ready}, 64'h1);
        check("rst_mid_queue", 64'(exp_q.size()), 64'h0);
        $display("reset during emit done");

        exp_push(80'h05, 1);
        run("u5_after_rst", 64'd5, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
